// File: rtl/bcd_display_scan_pkg.sv
// Shared constants and types for the multiplexed BCD seven-segment scan driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package bcd_display_scan_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;

  localparam logic [0:9][6:0] SEG_DIGIT = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  localparam logic [1:0] DIG_UNITS    = 2'd0;
  localparam logic [1:0] DIG_TENS     = 2'd1;
  localparam logic [1:0] DIG_HUNDREDS = 2'd2;
  localparam logic [1:0] DIG_SIGN     = 2'd3;

  typedef struct packed {
    logic       err;
    logic       neg;
    logic [1:0] hund;
    logic [3:0] tens;
    logic [3:0] units;
  } disp_t;

endpackage

// File: rtl/bcd_display_scan_seg7_decode.sv
// Combinational 4-bit value to active-low seven-segment pattern; values above 9 show 'E'.
module seg7_decode
  import bcd_display_scan_pkg::*;
(
  input  logic [3:0] value_i,
  output logic [6:0] seg_o
);

  // NOTE: assign a default first in every always_comb so no path leaves the output unassigned (no latch).
  always_comb begin
    seg_o = SEG_E;
    if (value_i <= 4'd9) seg_o = SEG_DIGIT[value_i];
  end

endmodule

// File: rtl/bcd_display_scan.sv
// 4-digit common-anode scan driver: prescaled digit rotation, leading-zero blanking,
// anti-ghost guard cycle and frame-boundary (tear-free) display updates.
module bcd_display_scan
  import bcd_display_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Units,
  input  logic [3:0] Tens,
  input  logic [1:0] Hundreds,
  input  logic       Negative,
  input  logic       Error,
  input  logic       Load,
  input  logic       Blank,
  output logic [6:0] Segments,
  output logic [3:0] Anodes,
  output logic       Frame
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  disp_t            pend_q, pend_d, disp_q, disp_d, live;
  logic             tick, boundary;
  logic [3:0]       dig_val;
  logic [6:0]       dig_seg, seg_d, seg_q;
  logic [3:0]       an_d, an_q;
  logic             frame_q;

  always_comb begin
    live     = '{err: Error, neg: Negative, hund: Hundreds, tens: Tens, units: Units};
    tick     = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    boundary = tick && (idx_q == DIG_SIGN);
    pend_d   = Load ? live : pend_q;
    // A Load landing on the boundary itself bypasses pending so it is not lost for a frame.
    disp_d   = boundary ? (Load ? live : pend_q) : disp_q;
  end

  // Outputs are built from next-state so segments already carry the new digit in the guard cycle.
  always_comb begin
    case (idx_d)
      DIG_TENS:     dig_val = disp_d.tens;
      DIG_HUNDREDS: dig_val = (disp_d.hund == 2'd3) ? 4'hF : {2'b00, disp_d.hund};
      default:      dig_val = disp_d.units;
    endcase
  end

  seg7_decode u_decode (
    .value_i (dig_val),
    .seg_o   (dig_seg)
  );

  always_comb begin
    seg_d = dig_seg;
    if (disp_d.err) begin
      case (idx_d)
        DIG_SIGN:               seg_d = SEG_E;
        DIG_HUNDREDS, DIG_TENS: seg_d = SEG_R;
        default:                seg_d = SEG_BLANK;
      endcase
    end else begin
      case (idx_d)
        DIG_TENS:     if (disp_d.hund == 2'd0 && disp_d.tens == 4'd0) seg_d = SEG_BLANK;
        DIG_HUNDREDS: if (disp_d.hund == 2'd0) seg_d = SEG_BLANK;
        DIG_SIGN:     seg_d = disp_d.neg ? SEG_MINUS : SEG_BLANK;
        default:      ;
      endcase
    end
    an_d = (tick || Blank) ? 4'hF : ~(4'b0001 << idx_d);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= DIG_UNITS;
      pend_q  <= '0;
      disp_q  <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= 4'hF;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      disp_q  <= disp_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      frame_q <= boundary;
    end
  end

  assign Segments = seg_q;
  assign Anodes   = an_q;
  assign Frame    = frame_q;

endmodule
